// File: rtl/shift_add_mult_param.sv
// shift_add_mult_param: sequential shift-add multiplier, WIDTH-bit operands, signed or unsigned,
// product left in {A,B} with sign/carry bit X.
module shift_add_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Signed,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, ADD = 3'd2, SHIFT = 3'd3, HOLD = 3'd4;
  logic [2:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic x_q, x_d, sg_q, sg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] ext_a, ext_m, sum;
  assign ext_a = {sg_q & a_q[WIDTH-1], a_q};
  assign ext_m = {sg_q & m_q[WIDTH-1], m_q};
  // the last partial product carries negative weight in two's complement
  assign sum = (sg_q && cnt_q == CW'(WIDTH - 1)) ? ext_a - ext_m : ext_a + ext_m;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    x_d = x_q;
    sg_d = sg_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (!Run) state_d = CLEAR;
        else if (!ClearA_LoadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = S;
        end
      end
      CLEAR: begin
        a_d = '0;
        x_d = 1'b0;
        m_d = S;
        sg_d = Signed;
        cnt_d = '0;
        state_d = ADD;
      end
      ADD: begin
        if (b_q[0]) {x_d, a_d} = sum;
        state_d = SHIFT;
      end
      SHIFT: begin
        {a_d, b_d} = {x_q, a_q, b_q[WIDTH-1:1]};
        x_d = sg_q & x_q;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_d < CW'(WIDTH)) ? ADD : HOLD;
      end
      HOLD: state_d = Run ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      x_q <= 1'b0;
      sg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      x_q <= x_d;
      sg_q <= sg_d;
      cnt_q <= cnt_d;
    end
  end
  assign Aval = a_q;
  assign Bval = b_q;
  assign X = x_q;
  assign Busy = (state_q == CLEAR) || (state_q == ADD) || (state_q == SHIFT);
  assign Done = (state_q == HOLD);
endmodule

// File: tb/tb_shift_add_mult_param.sv
// tb_shift_add_mult_param: WIDTH=8 and WIDTH=4 instances driven in lockstep, checked against
// constant vectors and an arithmetic product model.
module tb_shift_add_mult_param;
  logic clk = 1'b0, rst_n, run_n, cl_n, sg;
  logic [7:0] s;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic x8, x4, busy8, busy4, done8, done4;
  int checks = 0, errors = 0;
  logic [7:0] mb8;
  logic [3:0] mb4;

  shift_add_mult_param #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst_n), .Run(run_n), .ClearA_LoadB(cl_n), .Signed(sg), .S(s),
    .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8), .Done(done8));
  shift_add_mult_param #(.WIDTH(4)) dut4 (
    .Clk(clk), .Reset(rst_n), .Run(run_n), .ClearA_LoadB(cl_n), .Signed(sg), .S(s[3:0]),
    .Aval(a4), .Bval(b4), .X(x4), .Busy(busy4), .Done(done4));

  always #5 clk = ~clk;

  typedef struct {
    logic sg;
    logic [7:0] b;
    logic [7:0] s;
    logic [15:0] p;
    logic x;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // exact product of two w-bit values, reduced to 2w bits
  function automatic logic [31:0] prod(input int w, input logic [31:0] m, input logic [31:0] b,
                                       input logic sgn);
    longint mm, bb, p, lim;
    lim = longint'(1) << w;
    mm = longint'(m) & (lim - 1);
    bb = longint'(b) & (lim - 1);
    if (sgn && ((mm >> (w - 1)) & 1) == 1) mm -= lim;
    if (sgn && ((bb >> (w - 1)) & 1) == 1) bb -= lim;
    p = (mm * bb) & ((longint'(1) << (2 * w)) - 1);
    return 32'(p);
  endfunction

  task automatic load(input logic [7:0] bv);
    @(negedge clk);
    cl_n = 1'b0;
    s = bv;
    @(negedge clk);
    cl_n = 1'b1;
    mb8 = bv;
    mb4 = bv[3:0];
    chk("load8", {23'd0, x8, a8}, 32'd0);
    chk("load8_b", {24'd0, b8}, {24'd0, bv});
    chk("load4_b", {28'd0, b4}, {28'd0, bv[3:0]});
  endtask

  // one operation; disturb=1 wiggles S and ClearA_LoadB mid-operation
  task automatic do_op(input logic sgn, input logic [7:0] sv, input bit disturb);
    logic [15:0] e8;
    logic [7:0] e4;
    int l8, l4, bz8, bz4;
    e8 = prod(8, {24'd0, sv}, {24'd0, mb8}, sgn);
    e4 = prod(4, {28'd0, sv[3:0]}, {28'd0, mb4}, sgn);
    s = sv;
    sg = sgn;
    run_n = 1'b0;
    l8 = -1;
    l4 = -1;
    bz8 = 0;
    bz4 = 0;
    for (int n = 1; n <= 200 && l8 < 0; n++) begin
      @(negedge clk);
      if (disturb && n == 5) begin
        s = ~sv;
        sg = ~sgn;
        cl_n = 1'b0;
      end
      if (disturb && n == 6) cl_n = 1'b1;
      bz8 += int'(busy8);
      bz4 += int'(busy4);
      if (done4 && l4 < 0) l4 = n - 1;
      if (done8 && l8 < 0) l8 = n - 1;
    end
    chk("lat8", l8, 17);
    chk("lat4", l4, 9);
    chk("busy8", bz8, 17);
    chk("busy4", bz4, 9);
    chk("prod8", {16'd0, a8, b8}, {16'd0, e8});
    chk("x8", {31'd0, x8}, {31'd0, sgn & e8[15]});
    chk("prod4", {24'd0, a4, b4}, {24'd0, e4});
    chk("x4", {31'd0, x4}, {31'd0, sgn & e4[7]});
    run_n = 1'b1;
    cl_n = 1'b1;
    @(negedge clk);
    chk("idle_done", {30'd0, done8, done4}, 32'd0);
    mb8 = e8[7:0];
    mb4 = e4[3:0];
  endtask

  vec_t vt[] = '{
    '{1'b1, 8'h07, 8'h3B, 16'h019D, 1'b0},
    '{1'b1, 8'h07, 8'hC5, 16'hFE63, 1'b1},
    '{1'b1, 8'hF9, 8'h3B, 16'hFE63, 1'b1},
    '{1'b1, 8'hF9, 8'hC5, 16'h019D, 1'b0},
    '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0},
    '{1'b1, 8'h80, 8'h80, 16'h4000, 1'b0},
    '{1'b0, 8'h80, 8'h80, 16'h4000, 1'b0},
    '{1'b1, 8'h00, 8'h85, 16'h0000, 1'b0},
    '{1'b0, 8'hFF, 8'h01, 16'h00FF, 1'b0},
    '{1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b0},
    '{1'b1, 8'h7F, 8'h80, 16'hC080, 1'b1},
    '{1'b1, 8'h08, 8'h08, 16'h0040, 1'b0}
  };

  initial begin
    int bz, dr;
    logic dp;
    rst_n = 1'b0;
    run_n = 1'b1;
    cl_n = 1'b1;
    sg = 1'b0;
    s = 8'h00;
    mb8 = 8'h00;
    mb4 = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset", {16'd0, a8, b8}, 32'd0);
    chk("reset_flags", {26'd0, x8, busy8, done8, x4, busy4, done4}, 32'd0);
    chk("reset4", {24'd0, a4, b4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      load(vt[i].b);
      do_op(vt[i].sg, vt[i].s, 1'b0);
      chk($sformatf("vec%0d", i), {16'd0, a8, b8}, {16'd0, vt[i].p});
      chk($sformatf("vec%0d_x", i), {31'd0, x8}, {31'd0, vt[i].x});
    end
    chk("w4_m8m8", {24'd0, a4, b4}, 32'h40);

    load(8'hFE);
    repeat (4) do_op(1'b1, 8'hFE, 1'b0);
    chk("chain", {16'd0, a8, b8}, 32'hFFE0);

    load(8'h07);
    s = 8'h3B;
    sg = 1'b1;
    run_n = 1'b0;
    bz = 0;
    dr = 0;
    dp = 1'b0;
    repeat (60) begin
      @(negedge clk);
      bz += int'(busy8);
      if (done8 && !dp) dr++;
      dp = done8;
    end
    chk("hold_busy", bz, 17);
    chk("hold_once", dr, 1);
    chk("hold_prod", {16'd0, a8, b8}, 32'h019D);
    run_n = 1'b1;
    @(negedge clk);

    load(8'h07);
    do_op(1'b1, 8'h3B, 1'b1);
    chk("disturb", {16'd0, a8, b8}, 32'h019D);

    load(8'h07);
    s = 8'h3B;
    sg = 1'b1;
    run_n = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {16'd0, a8, b8}, 32'd0);
    chk("async_rst_flags", {26'd0, x8, busy8, done8, x4, busy4, done4}, 32'd0);
    chk("async_rst4", {24'd0, a4, b4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mb8 = 8'h00;
    mb4 = 4'h0;
    do_op(1'b1, 8'h3B, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) != 0) load(8'($urandom));
      do_op(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_add_mult_param.md
# shift_add_mult_param

Parametrised sequential shift-add multiplier, the successor of the fixed 8-bit lab multiplier. It multiplies a latched operand from the switch bus S by register B and leaves the 2*WIDTH-bit product in A:B (A high half, B low half), with a sign/carry bit X. The block supports runtime signed or unsigned mode, latches S at start so the switches may change mid-operation, and reports Busy/Done. It sits between the board button/switch inputs and the hex display drivers, which are external.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state immediately.
- Run  in  1  active-low start button; one operation per press.
- ClearA_LoadB  in  1  active-low; in IDLE clears A and X and loads B from S.
- Signed  in  1  1 = two's-complement multiply, 0 = unsigned; sampled at start.
- S  in  WIDTH  switch operand bus.
- Aval  out  WIDTH  register A, high half of the product.
- Bval  out  WIDTH  register B, low half of the product.
- X  out  1  sign-extension bit (signed mode) or carry bit (unsigned mode).
- Busy  out  1  high in states CLEAR, ADD and SHIFT.
- Done  out  1  high in HOLD, for as long as Run stays low after completion.

## Operation
- Registers: A, B, M (latched S), X, mode bit SG, iteration counter cnt (width ceil(log2(WIDTH))+1).
- Reset values: A=0, B=0, M=0, X=0, SG=0, cnt=0, Busy=0, Done=0, state=IDLE.
- IDLE:
  - Run low -> CLEAR. Run has priority over ClearA_LoadB if both are low.
  - Otherwise, ClearA_LoadB low -> A<=0, X<=0, B<=S; stay in IDLE.
- CLEAR: A<=0, X<=0, M<=S, SG<=Signed, cnt<=0 -> ADD. B is untouched, so a chained multiply uses the previous low half as multiplicand.
- ADD: the operation depends on B[0], SG and the iteration.
  - B[0]=0: registers unchanged.
  - B[0]=1, SG=1, cnt<WIDTH-1: {X,A} <= sext(A)+sext(M), WIDTH+1-bit sum.
  - B[0]=1, SG=1, cnt=WIDTH-1: {X,A} <= sext(A)-sext(M), WIDTH+1-bit difference.
  - B[0]=1, SG=0: {X,A} <= zext(A)+zext(M); X receives the carry.
  - Next state: SHIFT.
- SHIFT: {X,A,B} is shifted right by one. The bit shifted into the top of A is X. New X = X if SG=1, else 0. cnt<=cnt+1. Next: ADD if cnt+1<WIDTH, else HOLD.
- HOLD: Done=1. Registers hold. Run high -> IDLE. Run still low -> stay in HOLD, with no retrigger.
- ClearA_LoadB is ignored outside IDLE. S and Signed are ignored after CLEAR.
- Arithmetic: the result equals the exact 2*WIDTH-bit product of M and the original B, interpreted signed if SG=1, unsigned otherwise. The signed case holds including M or B = -2^(WIDTH-1).
- Reset asserted mid-operation: every register returns to its reset value asynchronously. After Reset deasserts, the block is in IDLE; if Run is still low, it restarts from CLEAR on the next edge.

## Timing
- Run sampled low in IDLE at edge 0 -> CLEAR in cycle 1, then WIDTH ADD/SHIFT pairs.
- Done first high 2*WIDTH+1 cycles after edge 0 (17 cycles for WIDTH=8).
- Busy high for exactly 2*WIDTH+1 cycles per operation.
- Aval/Bval/X are registered outputs. Their values are intermediate while Busy=1 and final from the first HOLD cycle onward.
- Minimum operation spacing: 2*WIDTH+3 cycles, covering HOLD and IDLE for at least one cycle each.
- The ClearA_LoadB load takes effect on the edge on which it is sampled low in IDLE. Holding it low reloads on every edge.

## Test plan
- Signed, WIDTH=8: load B=7 (S=0x07, ClearA_LoadB pulse), S=0x3B, Run pulse -> Aval=0x01, Bval=0x9D, Done after 17 cycles.
- Sign combinations: 7*-59, -7*59 -> 0xFE/0x63 with X=1. -7*-59 -> 0x01/0x9D with X=0.
- Chained: B=-2, then four Run presses with S=0xFE -> Aval=0xFF, Bval=0xE0.
- Unsigned and corner cases: Signed=0, B=0xFF, S=0xFF -> 0xFE/0x01, X=0. Signed=1, B=0x80, S=0x80 -> 0x40/0x00.
- Control robustness:
  - Run held low for 60 cycles -> exactly one operation.
  - S changed and ClearA_LoadB pulsed while Busy -> result unchanged.
  - Reset pulsed at cycle 5 of an operation -> all outputs 0 immediately.
- WIDTH=4 instance, signed: -8*-8 -> Aval=0x4, Bval=0x0, Done after 9 cycles. Random signed and unsigned operands checked against a reference product (1000 iterations).
